// File: rtl/unstripe_sched.sv
// unstripe_sched: merges two byte lanes back into one stream on clk_2f.
// Each lane feeds a small FIFO that absorbs lane-to-lane skew. Bytes leave
// strictly as lane 0, lane 1, lane 0, ... at most one per edge. Excess skew
// and dropped bytes raise sticky error flags. A running byte count is kept.
module unstripe_sched #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int SKEW_MAX = 3
) (
  input  logic             clk_2f,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] lane_0,
  input  logic             valid_0,
  input  logic [WIDTH-1:0] lane_1,
  input  logic             valid_1,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active_lane,
  output logic             aligned,
  output logic             skew_err,
  output logic             ovf_err,
  output logic [15:0]      byte_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] SKEW_LIM = OCC_W'(SKEW_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Per-lane views, packed so each generate instance can drive its own slice.
  logic [1:0][WIDTH-1:0] lane_data;
  logic [1:0]            lane_valid;
  logic [1:0][OCC_W-1:0] occ;
  logic [1:0][WIDTH-1:0] head;
  logic [1:0]            push_ok;
  logic [1:0]            pop_lane;
  logic [1:0]            ovf_set;

  logic             pop_en;
  logic             pop_sel;
  logic             skew_trip;
  logic [OCC_W-1:0] occ_diff;
  logic             next_lane_reg;

  logic [WIDTH-1:0] data_out_reg;
  logic             valid_out_reg;
  logic             active_lane_reg;
  logic             skew_err_reg;
  logic             ovf_err_reg;
  logic [15:0]      byte_cnt_reg;

  assign lane_data[0]  = lane_0;
  assign lane_data[1]  = lane_1;
  assign lane_valid[0] = valid_0;
  assign lane_valid[1] = valid_1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [OCC_W-1:0] occ_reg;
    logic             full;

    assign full         = (occ_reg == FULL_OCC);
    assign occ[gi]      = occ_reg;
    assign head[gi]     = mem[rd_ptr_reg];
    assign pop_lane[gi] = pop_en && (pop_sel == 1'(gi));
    // A full buffer still takes a byte when its head leaves on the same edge.
    assign push_ok[gi]  = lane_valid[gi] && (state_reg != ERR) && (!full || pop_lane[gi]);
    assign ovf_set[gi]  = lane_valid[gi] && (state_reg != ERR) && full && !pop_lane[gi];

    // Buffer storage; contents need no clearing because the pointers define validity.
    always_ff @(posedge clk_2f) begin
      if (push_ok[gi]) begin
        mem[wr_ptr_reg] <= lane_data[gi];
      end
    end

    // Write/read pointers and occupancy of this lane's buffer.
    always_ff @(posedge clk_2f or posedge reset) begin
      if (reset) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        occ_reg    <= '0;
      end else if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        occ_reg    <= '0;
      end else begin
        if (push_ok[gi]) begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
        if (pop_lane[gi]) begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
        if (push_ok[gi] && !pop_lane[gi]) begin
          occ_reg <= occ_reg + 1'b1;
        end else if (!push_ok[gi] && pop_lane[gi]) begin
          occ_reg <= occ_reg - 1'b1;
        end
      end
    end
  end

  // Skew detection and pop selection; kept apart from push so there is no loop.
  always_comb begin
    occ_diff  = (occ[0] >= occ[1]) ? (occ[0] - occ[1]) : (occ[1] - occ[0]);
    skew_trip = ((state_reg == ALIGN) || (state_reg == RUN)) && (occ_diff > SKEW_LIM);
    pop_en    = 1'b0;
    pop_sel   = next_lane_reg;
    case (state_reg)
      ALIGN: begin
        if (!skew_trip && (occ[0] != '0) && (occ[1] != '0)) begin
          pop_en  = 1'b1;
          pop_sel = 1'b0;
        end
      end
      RUN: begin
        if (!skew_trip && (occ[next_lane_reg] != '0)) begin
          pop_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Next-state logic; RUN only falls back to IDLE on a drained pair boundary.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (|push_ok) begin
          state_next = ALIGN;
        end
      end
      ALIGN: begin
        if (skew_trip) begin
          state_next = ERR;
        end else if (pop_en) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (skew_trip) begin
          state_next = ERR;
        end else if (!next_lane_reg && (occ[0] == '0) && (occ[1] == '0) && !(|push_ok)) begin
          state_next = IDLE;
        end
      end
      default: ;
    endcase
  end

  // State register; ERR is left only through flush or reset.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else if (flush) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Output byte, lane tracking, byte count and sticky error flags.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      data_out_reg    <= '0;
      valid_out_reg   <= 1'b0;
      active_lane_reg <= 1'b0;
      next_lane_reg   <= 1'b0;
      byte_cnt_reg    <= '0;
      skew_err_reg    <= 1'b0;
      ovf_err_reg     <= 1'b0;
    end else if (flush) begin
      data_out_reg    <= '0;
      valid_out_reg   <= 1'b0;
      active_lane_reg <= 1'b0;
      next_lane_reg   <= 1'b0;
      byte_cnt_reg    <= '0;
      skew_err_reg    <= 1'b0;
      ovf_err_reg     <= 1'b0;
    end else begin
      valid_out_reg <= pop_en;
      if (pop_en) begin
        data_out_reg    <= head[pop_sel];
        active_lane_reg <= pop_sel;
        next_lane_reg   <= ~pop_sel;
        byte_cnt_reg    <= byte_cnt_reg + 1'b1;
      end
      if (skew_trip) begin
        skew_err_reg <= 1'b1;
      end
      if (|ovf_set) begin
        ovf_err_reg <= 1'b1;
      end
    end
  end

  assign data_out    = data_out_reg;
  assign valid_out   = valid_out_reg;
  assign active_lane = active_lane_reg;
  assign aligned     = (state_reg == RUN);
  assign skew_err    = skew_err_reg;
  assign ovf_err     = ovf_err_reg;
  assign byte_cnt    = byte_cnt_reg;

endmodule

// File: tb/tb_unstripe_sched.sv
// Testbench for unstripe_sched: a vector table for pair streaming and gapped
// traffic, plus hand-written sequences for skew, flush, overflow and reset.
// Expected output bytes go into a scoreboard queue when they are driven.
module tb_unstripe_sched;

  logic        clk_2f = 1'b0;
  logic        reset;
  logic        flush;
  logic [7:0]  lane_0;
  logic        valid_0;
  logic [7:0]  lane_1;
  logic        valid_1;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        active_lane;
  logic        aligned;
  logic        skew_err;
  logic        ovf_err;
  logic [15:0] byte_cnt;

  always #5 clk_2f = ~clk_2f;

  unstripe_sched #(.WIDTH(8), .DEPTH(4), .SKEW_MAX(3)) dut (
    .clk_2f     (clk_2f),
    .reset      (reset),
    .flush      (flush),
    .lane_0     (lane_0),
    .valid_0    (valid_0),
    .lane_1     (lane_1),
    .valid_1    (valid_1),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .active_lane(active_lane),
    .aligned    (aligned),
    .skew_err   (skew_err),
    .ovf_err    (ovf_err),
    .byte_cnt   (byte_cnt)
  );

  typedef struct {
    logic [7:0] data;
    logic       lane;
  } exp_t;

  typedef struct {
    logic        v0;
    logic [7:0]  d0;
    logic        v1;
    logic [7:0]  d1;
    logic        e_valid;
    logic        e_aligned;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NV = 17;

  exp_t sbq[$];
  vec_t vecs[NV];
  int   errors = 0;
  int   checks = 0;

  // Overflow-phase monitor state: outputs must alternate and rise per lane.
  bit   ovf_mode = 1'b0;
  bit   ovf_exp_lane;
  int   ovf_last0;
  int   ovf_last1;
  int   ovf_n0;
  int   ovf_n1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic v0, input logic [7:0] d0, input logic v1,
                              input logic [7:0] d1, input logic ev, input logic ea,
                              input logic [15:0] ec);
    vec_t r;
    r.v0 = v0; r.d0 = d0; r.v1 = v1; r.d1 = d1;
    r.e_valid = ev; r.e_aligned = ea; r.e_cnt = ec;
    return r;
  endfunction

  task automatic drive(input logic v0, input logic [7:0] d0, input logic v1,
                       input logic [7:0] d1, input bit track);
    exp_t e;
    valid_0 = v0;
    lane_0  = d0;
    valid_1 = v1;
    lane_1  = d1;
    if (track) begin
      if (v0) begin
        e.data = d0; e.lane = 1'b0; sbq.push_back(e);
      end
      if (v1) begin
        e.data = d1; e.lane = 1'b1; sbq.push_back(e);
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (valid_out !== 1'b1) return;
    if (ovf_mode) begin
      check("ovf_lane_alt", {31'b0, active_lane}, {31'b0, ovf_exp_lane});
      check("ovf_lane_src", {31'b0, data_out[0]}, {31'b0, active_lane});
      if (active_lane == 1'b0) begin
        check("ovf_order0", {31'b0, (int'(data_out) > ovf_last0)}, 32'd1);
        ovf_last0 = int'(data_out);
        ovf_n0++;
      end else begin
        check("ovf_order1", {31'b0, (int'(data_out) > ovf_last1)}, 32'd1);
        ovf_last1 = int'(data_out);
        ovf_n1++;
      end
      ovf_exp_lane = ~ovf_exp_lane;
      return;
    end
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_extra: got data %0h lane %0d, expected no output", data_out, active_lane);
      return;
    end
    e = sbq.pop_front();
    check("sb_data", {24'b0, data_out}, {24'b0, e.data});
    check("sb_lane", {31'b0, active_lane}, {31'b0, e.lane});
  endtask

  task automatic step();
    @(posedge clk_2f);
    #1;
    monitor();
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Table: staggered FF/EE/DD/CC stream, then gapped pairs 03/04, AA/99, 07/08.
    vecs[0]  = mk(1, 8'hFF, 0, 8'h00, 0, 0, 16'd0);
    vecs[1]  = mk(0, 8'h00, 1, 8'hEE, 0, 0, 16'd0);
    vecs[2]  = mk(1, 8'hDD, 0, 8'h00, 1, 1, 16'd1);
    vecs[3]  = mk(0, 8'h00, 1, 8'hCC, 1, 1, 16'd2);
    vecs[4]  = mk(0, 8'h00, 0, 8'h00, 1, 1, 16'd3);
    vecs[5]  = mk(0, 8'h00, 0, 8'h00, 1, 1, 16'd4);
    vecs[6]  = mk(0, 8'h00, 0, 8'h00, 0, 0, 16'd4);
    vecs[7]  = mk(1, 8'h03, 1, 8'h04, 0, 0, 16'd4);
    vecs[8]  = mk(0, 8'h00, 0, 8'h00, 1, 1, 16'd5);
    vecs[9]  = mk(0, 8'h00, 0, 8'h00, 1, 1, 16'd6);
    vecs[10] = mk(1, 8'hAA, 1, 8'h99, 0, 1, 16'd6);
    vecs[11] = mk(0, 8'h00, 0, 8'h00, 1, 1, 16'd7);
    vecs[12] = mk(0, 8'h00, 0, 8'h00, 1, 1, 16'd8);
    vecs[13] = mk(1, 8'h07, 1, 8'h08, 0, 1, 16'd8);
    vecs[14] = mk(0, 8'h00, 0, 8'h00, 1, 1, 16'd9);
    vecs[15] = mk(0, 8'h00, 0, 8'h00, 1, 1, 16'd10);
    vecs[16] = mk(0, 8'h00, 0, 8'h00, 0, 0, 16'd10);

    #2;
    check("rst_data_out", {24'b0, data_out}, 32'h0);
    check("rst_valid_out", {31'b0, valid_out}, 32'h0);
    check("rst_active_lane", {31'b0, active_lane}, 32'h0);
    check("rst_aligned", {31'b0, aligned}, 32'h0);
    check("rst_skew_err", {31'b0, skew_err}, 32'h0);
    check("rst_ovf_err", {31'b0, ovf_err}, 32'h0);
    check("rst_byte_cnt", {16'b0, byte_cnt}, 32'h0);
    @(posedge clk_2f);
    #1;
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, 1'b1);
      step();
      check($sformatf("vec%0d_valid", i), {31'b0, valid_out}, {31'b0, vecs[i].e_valid});
      check($sformatf("vec%0d_aligned", i), {31'b0, aligned}, {31'b0, vecs[i].e_aligned});
      check($sformatf("vec%0d_cnt", i), {16'b0, byte_cnt}, {16'b0, vecs[i].e_cnt});
      check($sformatf("vec%0d_skew", i), {31'b0, skew_err}, 32'h0);
      check($sformatf("vec%0d_ovf", i), {31'b0, ovf_err}, 32'h0);
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("table_sb_drained", sbq.size(), 32'd0);

    // Skew fault: four lane-0 bytes with nothing on lane 1.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hA4, 1'b0, 8'h00, 1'b0);
      step();
      check("skew_pre_valid", {31'b0, valid_out}, 32'h0);
      check("skew_pre_err", {31'b0, skew_err}, 32'h0);
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    step();
    check("skew_err_set", {31'b0, skew_err}, 32'h1);
    check("skew_aligned", {31'b0, aligned}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 8'h00, 1'b1, 8'(8'h50 + i), 1'b0);
      step();
      check("err_valid_out", {31'b0, valid_out}, 32'h0);
      check("err_skew_sticky", {31'b0, skew_err}, 32'h1);
      check("err_push_ignored", {31'b0, ovf_err}, 32'h0);
    end
    check("err_byte_cnt", {16'b0, byte_cnt}, 32'd10);
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Flush recovery, then a clean 62/12 pair.
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_skew_err", {31'b0, skew_err}, 32'h0);
    check("flush_byte_cnt", {16'b0, byte_cnt}, 32'h0);
    check("flush_aligned", {31'b0, aligned}, 32'h0);
    check("flush_valid_out", {31'b0, valid_out}, 32'h0);
    drive(1'b1, 8'h62, 1'b1, 8'h12, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("flush_pair_wait", {31'b0, valid_out}, 32'h0);
    step();
    check("flush_pair_first", {31'b0, valid_out}, 32'h1);
    step();
    check("flush_pair_cnt", {16'b0, byte_cnt}, 32'd2);
    step();
    check("flush_pair_idle", {31'b0, aligned}, 32'h0);
    check("flush_sb_drained", sbq.size(), 32'd0);

    // Overflow: both lanes every edge, lane 0 even bytes, lane 1 odd bytes.
    flush = 1'b1;
    step();
    flush = 1'b0;
    ovf_mode = 1'b1;
    ovf_exp_lane = 1'b0;
    ovf_last0 = -1;
    ovf_last1 = -1;
    ovf_n0 = 0;
    ovf_n1 = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'(2 * i), 1'b1, 8'(2 * i + 1), 1'b0);
      step();
      check($sformatf("ovf_flag_e%0d", i + 1), {31'b0, ovf_err}, {31'b0, (i >= 7)});
      check("ovf_no_skew", {31'b0, skew_err}, 32'h0);
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    repeat (12) step();
    check("ovf_byte_cnt", {16'b0, byte_cnt}, 32'd27);
    check("ovf_lane0_bytes", ovf_n0, 32'd14);
    check("ovf_lane1_bytes", ovf_n1, 32'd13);
    check("ovf_stall_aligned", {31'b0, aligned}, 32'h1);
    check("ovf_stall_valid", {31'b0, valid_out}, 32'h0);
    ovf_mode = 1'b0;

    // Reset mid-run: asynchronous reset between edges while the stream is in RUN.
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b1, 8'hFF, 1'b0, 8'h00, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b1, 8'hEE, 1'b1);
    step();
    drive(1'b1, 8'hDD, 1'b0, 8'h00, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("mid_run_valid", {31'b0, valid_out}, 32'h1);
    check("mid_run_aligned", {31'b0, aligned}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid_out", {31'b0, valid_out}, 32'h0);
    check("arst_data_out", {24'b0, data_out}, 32'h0);
    check("arst_active_lane", {31'b0, active_lane}, 32'h0);
    check("arst_aligned", {31'b0, aligned}, 32'h0);
    check("arst_byte_cnt", {16'b0, byte_cnt}, 32'h0);
    sbq.delete();
    #2;
    reset = 1'b0;
    drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    step();
    step();
    check("post_rst_cnt", {16'b0, byte_cnt}, 32'd2);
    step();
    check("post_rst_idle", {31'b0, aligned}, 32'h0);
    check("post_rst_sb_drained", sbq.size(), 32'd0);
    check("post_rst_errs", {30'b0, skew_err, ovf_err}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
